// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parameterised UART receiver.
//   state_t          receiver FSM states
//   PARITY_*         values for the PARITY parameter
//   DEFAULT_CLK_DIV  default clocks per bit (12 MHz / 230400)
//   parity_error()   maps a running ones-count parity to an error flag
package uart_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned DEFAULT_CLK_DIV = 52;

  // ones_odd is the XOR of all data bits and the received parity bit.
  function automatic logic parity_error(input int unsigned mode, input logic ones_odd);
    logic err;
    err = 1'b0;
    if (mode == PARITY_EVEN) begin
      err = ones_odd;
    end else if (mode == PARITY_ODD) begin
      err = ~ones_odd;
    end
    return err;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so the line reads idle straight out of reset.
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   d      asynchronous input
//   q      synchronized output
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with valid/ready output.
//   Parameters: CLK_DIV (clocks per bit), DATA_BITS (5..9),
//               PARITY (0 none, 1 even, 2 odd), STOP_BITS (1 or 2).
//   clk, reset    clock and synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   m_data        received word (LSB first on the line)
//   m_frame_err   a stop sample of m_data was low
//   m_parity_err  parity mismatch for m_data (0 with PARITY none)
//   m_valid       m_data and flags are valid; held until m_ready
//   m_ready       consumer accepts the beat
//   overrun       1-cycle pulse when a completed word is dropped
//   break_det     1-cycle pulse on a break condition
//   line_ok       line idle has been qualified
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PARITY_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 line_ok
);

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  logic                 rx_s;
  state_t               state;
  logic [TW-1:0]        timer;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 all_zero;
  logic                 ferr;
  logic                 bit_tick;
  logic                 half_tick;
  logic                 par_err;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // A sample is taken on the clock whose increment would bring the timer to
  // CLK_DIV/2 (start) or CLK_DIV (other bits); the timer then restarts at 0,
  // so it never exceeds CLK_DIV-1 and fits in $clog2(CLK_DIV) bits.
  always_comb begin
    bit_tick  = (timer == BIT_LAST);
    half_tick = (timer == HALF_LAST);
    par_err   = parity_error(PARITY, par_acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_WAIT_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      all_zero     <= 1'b0;
      ferr         <= 1'b0;
      m_data       <= '0;
      m_frame_err  <= 1'b0;
      m_parity_err <= 1'b0;
      m_valid      <= 1'b0;
      overrun      <= 1'b0;
      break_det    <= 1'b0;
      line_ok      <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;

      // Handshake retire; a load below in the same cycle takes precedence.
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        ST_WAIT_IDLE: begin
          if (!rx_s) begin
            timer <= '0;
          end else if (bit_tick) begin
            timer   <= '0;
            state   <= ST_IDLE;
            line_ok <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (half_tick) begin
            timer <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              bit_cnt  <= '0;
              par_acc  <= 1'b0;
              all_zero <= 1'b1;
              ferr     <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_tick) begin
            timer   <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ rx_s;
            if (rx_s) begin
              all_zero <= 1'b0;
            end
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_PARITY: begin
          if (bit_tick) begin
            timer   <= '0;
            par_acc <= par_acc ^ rx_s;
            if (rx_s) begin
              all_zero <= 1'b0;
            end
            state <= ST_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_STOP: begin
          if (bit_tick) begin
            timer <= '0;
            if (bit_cnt == '0 && all_zero && !rx_s) begin
              // Break: nothing delivered, line must requalify as idle.
              break_det <= 1'b1;
              line_ok   <= 1'b0;
              bit_cnt   <= '0;
              state     <= ST_WAIT_IDLE;
            end else if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= ST_IDLE;
              if (!m_valid || m_ready) begin
                m_data       <= shreg;
                m_frame_err  <= ferr | ~rx_s;
                m_parity_err <= par_err;
                m_valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              ferr    <= ferr | ~rx_s;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state   <= ST_WAIT_IDLE;
          timer   <= '0;
          bit_cnt <= '0;
          line_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_DIV, default 52, meaning clk cycles per bit (12 MHz / 230400); legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset: synchronous, active-high.
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port m_data  output  DATA_BITS  received word, LSB first on the line.
REQ-009 SHALL have port m_frame_err  output  1  stop bit of m_data was sampled low.
REQ-010 SHALL have port m_parity_err  output  1  parity mismatch for m_data; always 0 when PARITY=0.
REQ-011 SHALL have port m_valid  output  1  m_data and flags are valid.
REQ-012 SHALL have port m_ready  input  1  consumer accepts the beat.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-014 SHALL have port break_det  output  1  one-cycle pulse on a detected break.
REQ-015 SHALL have port line_ok  output  1  high once line idle is qualified (states other than WAIT_IDLE).

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer (rx_s) before any use.
REQ-017 SHALL implement states WAIT_IDLE, IDLE, START, DATA, PARITY, STOP.
REQ-018 WAIT_IDLE: SHALL move to IDLE after rx_s has been high for CLK_DIV consecutive clocks; any low sample restarts the count.
REQ-019 IDLE: SHALL move to START on the first clock with rx_s low; the bit timer clears to 0.
REQ-020 START: SHALL sample rx_s when the timer reaches CLK_DIV/2 (integer division); low -> DATA, high -> IDLE as a false start with no output.
REQ-021 DATA/PARITY/STOP: SHALL sample every CLK_DIV clocks after the previous sample; DATA_BITS samples, LSB first, then 1 parity sample if PARITY!=0, then STOP_BITS stop samples.
REQ-022 Parity: SHALL flag an error when even parity has an odd count of ones over data plus parity bit, or odd parity has an even count.
REQ-023 Frame error: SHALL set the flag if any stop sample is low.
REQ-024 After the last stop sample SHALL return to IDLE in the same cycle so a start bit can be detected on the next clock.
REQ-025 Break: all data bits 0, parity bit 0 (if present) and first stop 0 SHALL give a break_det pulse, deliver no word, and go to WAIT_IDLE.
REQ-026 Output: on the last stop sample with m_valid=0, or m_valid=1 and m_ready=1, SHALL load m_data and the flags and set m_valid on the next clock.
REQ-027 Handshake: m_valid SHALL clear the cycle after m_valid&&m_ready unless a new word loads that same cycle; m_data and flags SHALL stay stable while m_valid&&!m_ready.
REQ-028 Overrun: a word completing while m_valid&&!m_ready SHALL be discarded, with overrun pulsed for 1 cycle and the held beat unchanged.
REQ-029 Bit timer width SHALL be $clog2(CLK_DIV); it SHALL never wrap inside a bit period.
REQ-030 Latency: m_valid SHALL rise exactly 1 clock after the final stop sample, which is 2 synchronizer clocks plus (CLK_DIV/2 + (N-1)*CLK_DIV) after the rx falling edge; N is the total bit count including start.

Reset
REQ-031 On reset, state SHALL be WAIT_IDLE, timers and counters 0, synchronizer flops 1, and m_valid, overrun, break_det, line_ok, m_frame_err and m_parity_err 0, m_data 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no output and no overrun.

Structure
REQ-033 Package uart_pkg SHALL hold the state encoding, the PARITY_NONE/EVEN/ODD constants, and default CLK_DIV=52.
REQ-034 A single sub-module uart_rx_sync (2-flop synchronizer, reset value 1) SHALL be instantiated.

Verification
REQ-035 8N1, CLK_DIV=52, send 0xA5 with m_ready=1 -> m_data=0xA5 and m_valid for 1 cycle, both flags 0, at the REQ-030 latency.
REQ-036 PARITY=1, send 0x01 with parity bit 0 -> m_data=0x01, m_parity_err=1; with parity bit 1 -> m_parity_err=0.
REQ-037 Send 0x3C with stop bit low -> m_data=0x3C, m_frame_err=1; receiver resyncs and takes the next 0x55 cleanly.
REQ-038 rx low glitch of 10 clocks in IDLE -> no m_valid, state back to IDLE.
REQ-039 m_ready=0, send 0x11 then 0x22 back-to-back -> m_data holds 0x11, 1-cycle overrun pulse at the 0x22 stop sample.
REQ-040 Hold rx low 12 bit times -> one break_det pulse, no m_valid, line_ok=0 until rx is high for 52 clocks; reset asserted mid-byte -> all outputs 0, next frame received correctly.
